// File: rtl/aligned_ram_pkg.sv
// Shared types and helpers for the word-aligned RAM read path.
// Response entries carry read data plus an error flag through the response queue.
package aligned_ram_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              error;
  } rsp_entry_t;

  // Only the byte-offset bits decide alignment, so only those are passed in.
  function automatic logic is_misaligned(input logic [BYTE_OFF_W-1:0] addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous FIFO of response entries with an occupancy count.
// DEPTH need not be a power of two; pointers wrap explicitly at DEPTH-1.
module rsp_fifo
  import aligned_ram_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  rsp_entry_t    push_entry,
  input  logic          pop,
  output rsp_entry_t    head,
  output logic [CW-1:0] count
);

  rsp_entry_t    store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      store[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset, so an empty queue presents zeros rather than stale data.
  assign head = (count != '0) ? store[rd_ptr] : '0;

endmodule

// File: rtl/aligned_ram_rd_port.sv
// Read port for a 1-cycle-latency SRAM: classifies byte-addressed requests,
// strobes the SRAM for good ones and queues in-order responses behind credits.
module aligned_ram_rd_port
  import aligned_ram_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int AW        = 8,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_error,
  output logic              mem_rd_en,
  output logic [AW-1:0]     mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [15:0]       rd_count,
  output logic [15:0]       err_count
);

  localparam int          CW      = $clog2(RSP_DEPTH + 1);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic          req_err;
  logic          accept;
  logic          inflight_v;
  logic          inflight_err;
  logic          pop;
  logic [CW-1:0] fifo_count;
  rsp_entry_t    push_entry;
  rsp_entry_t    head;

  always_comb begin
    req_err = is_misaligned(req_addr[BYTE_OFF_W-1:0]) ||
              ({2'b00, req_addr[31:2]} >= DEPTH_W);
  end

  // Credit counts the in-flight read too, so its push can never overflow the queue.
  assign req_ready = !rst && ((int'(fifo_count) + int'(inflight_v)) < RSP_DEPTH);
  assign accept    = req_valid && req_ready;
  assign mem_rd_en = accept && !req_err;
  assign mem_addr  = req_addr[AW+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_v   <= 1'b0;
      inflight_err <= 1'b0;
    end else begin
      inflight_v <= accept;
      if (accept) begin
        inflight_err <= req_err;
      end
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.data  = inflight_err ? '0 : mem_rdata;
    push_entry.error = inflight_err;
  end

  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = head.data;
  assign rsp_error = head.error;

  rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_v),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count  <= '0;
      err_count <= '0;
    end else if (accept) begin
      if (!req_err && rd_count != 16'hFFFF) begin
        rd_count <= rd_count + 16'd1;
      end
      if (req_err && err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_aligned_ram_rd_port.sv
// Directed bench for aligned_ram_rd_port: single-read vector table, then
// backpressure, streaming and mid-stream reset sequences against an SRAM model.
module tb_aligned_ram_rd_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [15:0] rd_count;
  logic [15:0] err_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mem [256];

  typedef struct {
    logic [31:0] addr;
    logic        err;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [8];
  vec_t exp_q [$];

  aligned_ram_rd_port dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_error (rsp_error),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .rd_count  (rd_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // SRAM model with one cycle of read latency
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One isolated read: accept cycle, in-flight cycle, response cycle, drained
  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    req_addr  = v.addr;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checkOutput({tag, " req_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, " mem_rd_en"}, 32'(mem_rd_en), 32'(!v.err));
    if (!v.err) begin
      checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'(v.addr[9:2]));
    end
    cycle();
    req_valid = 1'b0;
    checkOutput({tag, " rsp_valid inflight"}, 32'(rsp_valid), 32'd0);
    cycle();
    checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, " rsp_data"}, rsp_data, v.data);
    checkOutput({tag, " rsp_error"}, 32'(rsp_error), 32'(v.err));
    cycle();
    checkOutput({tag, " rsp_valid drained"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int issued;
    int got;
    int stalls;
    int stale;
    logic [15:0] rd0;
    logic [15:0] er0;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h1000_0000 + 32'(i);
    end
    mem[4] = 32'hDEAD_BEEF;

    vecs[0] = '{addr: 32'h0000_0010, err: 1'b0, data: 32'hDEAD_BEEF};
    vecs[1] = '{addr: 32'h0000_0013, err: 1'b1, data: 32'h0};
    vecs[2] = '{addr: 32'h0000_0400, err: 1'b1, data: 32'h0};
    vecs[3] = '{addr: 32'h0000_03FC, err: 1'b0, data: 32'h1000_00FF};
    vecs[4] = '{addr: 32'h0000_0000, err: 1'b0, data: 32'h1000_0000};
    vecs[5] = '{addr: 32'h0000_0002, err: 1'b1, data: 32'h0};
    vecs[6] = '{addr: 32'hFFFF_FFFC, err: 1'b1, data: 32'h0};
    vecs[7] = '{addr: 32'h0000_0204, err: 1'b0, data: 32'h1000_0081};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;

    cycle();
    checkOutput("reset req_ready c1", 32'(req_ready), 32'd0);
    cycle();
    checkOutput("reset req_ready c2", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle req_ready", 32'(req_ready), 32'd1);
    checkOutput("idle rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("idle rsp_data", rsp_data, 32'd0);
    checkOutput("idle rsp_error", 32'(rsp_error), 32'd0);
    checkOutput("idle rd_count", 32'(rd_count), 32'd0);
    checkOutput("idle err_count", 32'(err_count), 32'd0);
    cycle();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], i);
      if (i == 2) begin
        checkOutput("after vec2 rd_count", 32'(rd_count), 32'd1);
        checkOutput("after vec2 err_count", 32'(err_count), 32'd2);
      end
    end
    checkOutput("table rd_count", 32'(rd_count), 32'd4);
    checkOutput("table err_count", 32'(err_count), 32'd4);

    // Backpressure: queue plus in-flight slot caps acceptance at four
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    issued    = 0;
    for (int c = 0; c < 8; c++) begin
      req_addr = 32'(issued) * 4;
      #1;
      if (req_ready) begin
        issued++;
      end
      cycle();
    end
    #1;
    checkOutput("bp accepted", 32'(issued), 32'd4);
    checkOutput("bp req_ready", 32'(req_ready), 32'd0);
    checkOutput("bp rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("bp head stable", rsp_data, mem[0]);

    rsp_ready = 1'b1;
    got       = 0;
    for (int c = 0; c < 30 && (got < 6 || issued < 6); c++) begin
      req_valid = (issued < 6);
      req_addr  = 32'(issued) * 4;
      #1;
      if (rsp_valid) begin
        checkOutput($sformatf("bp rsp%0d data", got), rsp_data, mem[got]);
        checkOutput($sformatf("bp rsp%0d error", got), 32'(rsp_error), 32'd0);
        got++;
      end
      if (req_valid && req_ready) begin
        issued++;
      end
      cycle();
    end
    req_valid = 1'b0;
    checkOutput("bp total issued", 32'(issued), 32'd6);
    checkOutput("bp total responses", 32'(got), 32'd6);

    // Streaming: every third request misaligned, one accept per cycle expected
    rd0    = rd_count;
    er0    = err_count;
    issued = 0;
    got    = 0;
    stalls = 0;
    exp_q.delete();
    for (int c = 0; c < 45 && (got < 20 || issued < 20); c++) begin
      req_valid = (issued < 20);
      req_addr  = (issued % 3 == 2) ? 32'(issued) * 4 + 1 : 32'(issued) * 4;
      #1;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("stream unexpected rsp", 32'd1, 32'd0);
        end else begin
          vec_t e;
          e = exp_q.pop_front();
          checkOutput($sformatf("stream rsp%0d data", got), rsp_data, e.data);
          checkOutput($sformatf("stream rsp%0d error", got), 32'(rsp_error), 32'(e.err));
        end
        got++;
      end
      if (req_valid) begin
        if (req_ready) begin
          vec_t e;
          e.addr = req_addr;
          e.err  = (issued % 3 == 2);
          e.data = e.err ? 32'h0 : mem[issued];
          exp_q.push_back(e);
          issued++;
        end else begin
          stalls++;
        end
      end
      cycle();
    end
    req_valid = 1'b0;
    checkOutput("stream accepted", 32'(issued), 32'd20);
    checkOutput("stream stalls", 32'(stalls), 32'd0);
    checkOutput("stream responses", 32'(got), 32'd20);
    checkOutput("stream rd delta", 32'(rd_count - rd0), 32'd14);
    checkOutput("stream err delta", 32'(err_count - er0), 32'd6);

    // Reset with two responses queued and one read in flight
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req_addr = 32'(c) * 4;
      cycle();
    end
    checkOutput("pre-reset rsp_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    cycle();
    checkOutput("mid-reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid-reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("mid-reset rd_count", 32'(rd_count), 32'd0);
    checkOutput("mid-reset err_count", 32'(err_count), 32'd0);
    rst       = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    stale     = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (rsp_valid) begin
        stale++;
      end
      cycle();
    end
    checkOutput("post-reset stale responses", 32'(stale), 32'd0);
    checkOutput("post-reset rd_count", 32'(rd_count), 32'd0);
    checkOutput("post-reset err_count", 32'(err_count), 32'd0);
    checkOutput("post-reset req_ready", 32'(req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
